// File: rtl/layers_mc_if.sv
// Image/kernel beat stream in, pooled result stream out, for the layers_mc stage.
interface layers_mc_if #(
  parameter int unsigned DEPTH_NB  = 4,
  parameter int unsigned GROUP_NB  = 4,
  parameter int unsigned IMG_WIDTH = 16,
  parameter int unsigned KER_WIDTH = 16
);
  logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0] kernel;
  logic                                   kernel_rdy;
  logic [GROUP_NB*IMG_WIDTH-1:0]          image;
  logic                                   image_last;
  logic                                   image_val;
  logic                                   image_rdy;
  logic [IMG_WIDTH*DEPTH_NB-1:0]          result;
  logic                                   result_val;
  logic                                   result_rdy;

  modport master (
    output kernel, image, image_last, image_val, result_rdy,
    input  kernel_rdy, image_rdy, result, result_val
  );

  modport slave (
    input  kernel, image, image_last, image_val, result_rdy,
    output kernel_rdy, image_rdy, result, result_val
  );
endinterface

// File: rtl/layers_mc.sv
// Multi-channel layer stage: per-channel MAC over image beats, max-pool, ReLU,
// saturating rescale into a credit-protected result FIFO.
module layers_mc #(
  parameter int unsigned DEPTH_NB   = 4,
  parameter int unsigned GROUP_NB   = 4,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned KER_WIDTH  = 16,
  parameter int unsigned ACC_GUARD  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned CFG_LAYERS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  layers_mc_if.slave            bus
);
  localparam int unsigned ACC_W  = IMG_WIDTH + KER_WIDTH + ACC_GUARD;
  localparam int unsigned PROD_W = IMG_WIDTH + KER_WIDTH;
  localparam int unsigned LANES  = DEPTH_NB * GROUP_NB;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CRD_W  = PTR_W + 1;
  localparam int unsigned RES_W  = IMG_WIDTH * DEPTH_NB;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-IMG_WIDTH+1){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-IMG_WIDTH+1){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

  logic [1:0] pend_mode, act_mode;
  logic [7:0] pend_pool, act_pool, pend_shift, act_shift;
  logic       cfg_idle, cfg_unused;
  logic       partial, rdy, accept, take, pop, absorb, pool_done;
  logic [CRD_W-1:0] credits, wr_ptr, rd_ptr;
  logic [7:0] pool_n, pool_cnt;

  logic signed [PROD_W-1:0] prod_next [LANES];
  logic signed [PROD_W-1:0] s1_prod   [LANES];
  logic                     s1_v, s1_last;
  logic signed [ACC_W-1:0]  lane_sum  [DEPTH_NB];
  logic signed [ACC_W-1:0]  s2_sum    [DEPTH_NB];
  logic                     s2_v, s2_last;
  logic signed [ACC_W-1:0]  acc       [DEPTH_NB];
  logic signed [ACC_W-1:0]  acc_next  [DEPTH_NB];
  logic signed [ACC_W-1:0]  s3_val    [DEPTH_NB];
  logic                     s3_v;
  logic signed [ACC_W-1:0]  pool_max  [DEPTH_NB];
  logic signed [ACC_W-1:0]  pool_cand [DEPTH_NB];
  logic signed [ACC_W-1:0]  s4_val    [DEPTH_NB];
  logic                     s4_v;
  logic signed [ACC_W-1:0]  relu_v    [DEPTH_NB];
  logic signed [ACC_W-1:0]  s5a_val   [DEPTH_NB];
  logic                     s5a_v;
  logic [RES_W-1:0]         sat_word, s5b_word;
  logic                     s5b_v;
  logic [RES_W-1:0]         fifo_mem  [FIFO_DEPTH];

  // head and mode[7:2] are carried in the cfg word but have no effect
  assign cfg_unused = ^{cfg_data[31:26], cfg_data[7:0]};

  assign rdy            = (credits != '0);
  assign bus.image_rdy  = rdy;
  assign bus.kernel_rdy = rdy;
  assign accept         = bus.image_val && rdy;
  assign take           = accept && bus.image_last;
  assign bus.result_val = (wr_ptr != rd_ptr);
  assign bus.result     = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign pop            = bus.result_val && bus.result_rdy;
  assign cfg_idle = !partial && (pool_cnt == '0) && !s1_v && !s2_v && !s3_v && !s4_v && !s5a_v && !s5b_v;

  assign pool_n    = (act_pool == '0) ? 8'd1 : act_pool;
  assign pool_done = act_mode[0] || (({1'b0, pool_cnt} + 9'd1) >= {1'b0, pool_n});
  assign absorb    = s3_v && !pool_done;

  always_comb begin
    for (int unsigned d = 0; d < DEPTH_NB; d++) begin
      for (int unsigned g = 0; g < GROUP_NB; g++) begin
        prod_next[d*GROUP_NB+g] =
          PROD_W'($signed(bus.kernel[(d*GROUP_NB+g)*KER_WIDTH +: KER_WIDTH])) *
          PROD_W'($signed(bus.image[g*IMG_WIDTH +: IMG_WIDTH]));
      end
    end
  end

  always_comb begin
    sat_word = '0;
    for (int unsigned d = 0; d < DEPTH_NB; d++) begin
      lane_sum[d] = '0;
      for (int unsigned g = 0; g < GROUP_NB; g++)
        lane_sum[d] = lane_sum[d] + ACC_W'(s1_prod[d*GROUP_NB+g]);
      acc_next[d]  = acc[d] + s2_sum[d];
      pool_cand[d] = (pool_cnt == '0 || s3_val[d] > pool_max[d]) ? s3_val[d] : pool_max[d];
      relu_v[d]    = s4_val[d];
      if (!act_mode[1] && s4_val[d][ACC_W-1])
        relu_v[d] = '0;
      if (s5a_val[d] > SAT_MAX)
        sat_word[d*IMG_WIDTH +: IMG_WIDTH] = SAT_MAX[IMG_WIDTH-1:0];
      else if (s5a_val[d] < SAT_MIN)
        sat_word[d*IMG_WIDTH +: IMG_WIDTH] = SAT_MIN[IMG_WIDTH-1:0];
      else
        sat_word[d*IMG_WIDTH +: IMG_WIDTH] = s5a_val[d][IMG_WIDTH-1:0];
    end
  end

  // Writes land in pending; active only follows pending once the datapath is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_mode  <= '0;
      pend_pool  <= 8'd1;
      pend_shift <= '0;
      act_mode   <= '0;
      act_pool   <= 8'd1;
      act_shift  <= '0;
    end else begin
      if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_LAYERS)) begin
        pend_mode  <= cfg_data[25:24];
        pend_pool  <= cfg_data[23:16];
        pend_shift <= cfg_data[15:8];
      end
      if (cfg_idle) begin
        act_mode  <= pend_mode;
        act_pool  <= pend_pool;
        act_shift <= pend_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= CRD_W'(FIFO_DEPTH);
      partial <= 1'b0;
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++)
        s1_prod[i] <= '0;
      for (int unsigned d = 0; d < DEPTH_NB; d++)
        s2_sum[d] <= '0;
    end else begin
      credits <= credits + CRD_W'(absorb) + CRD_W'(pop) - CRD_W'(take);
      if (accept)
        partial <= !bus.image_last;
      s1_v    <= accept;
      s1_last <= bus.image_last;
      if (accept)
        s1_prod <= prod_next;
      s2_v    <= s1_v;
      s2_last <= s1_last;
      if (s1_v)
        s2_sum <= lane_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_v     <= 1'b0;
      s4_v     <= 1'b0;
      s5a_v    <= 1'b0;
      s5b_v    <= 1'b0;
      pool_cnt <= '0;
      s5b_word <= '0;
      for (int unsigned d = 0; d < DEPTH_NB; d++) begin
        acc[d]      <= '0;
        s3_val[d]   <= '0;
        pool_max[d] <= '0;
        s4_val[d]   <= '0;
        s5a_val[d]  <= '0;
      end
    end else begin
      s3_v <= s2_v && s2_last;
      if (s2_v) begin
        for (int unsigned d = 0; d < DEPTH_NB; d++) begin
          acc[d] <= s2_last ? '0 : acc_next[d];
          if (s2_last)
            s3_val[d] <= acc_next[d];
        end
      end
      s4_v <= s3_v && pool_done;
      if (s3_v) begin
        pool_cnt <= pool_done ? '0 : pool_cnt + 8'd1;
        for (int unsigned d = 0; d < DEPTH_NB; d++) begin
          if (pool_done)
            s4_val[d] <= pool_cand[d];
          else
            pool_max[d] <= pool_cand[d];
        end
      end
      s5a_v <= s4_v;
      if (s4_v)
        for (int unsigned d = 0; d < DEPTH_NB; d++)
          s5a_val[d] <= relu_v[d] >>> act_shift;
      s5b_v <= s5a_v;
      if (s5a_v)
        s5b_word <= sat_word;
    end
  end

  // Credits guarantee a free slot for every push, so no full check is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        fifo_mem[i] <= '0;
    end else begin
      if (s5b_v) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= s5b_word;
        wr_ptr <= wr_ptr + CRD_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + CRD_W'(1);
    end
  end
endmodule

// File: tb/tb_layers_mc.sv
// Bench for layers_mc: directed cases with fixed expectations, then randomized
// vectors scored against a dot-product/pool/rescale reference model.
module tb_layers_mc;
  localparam int unsigned DEPTH_NB   = 4;
  localparam int unsigned GROUP_NB   = 4;
  localparam int unsigned IMG_WIDTH  = 16;
  localparam int unsigned KER_WIDTH  = 16;
  localparam int unsigned CFG_LAYERS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic        cfg_valid = 1'b0;
  logic        fixed_rdy = 1'b1;
  logic        rand_rdy = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] exp_q [$];

  logic [1:0]  m_mode;
  int          m_pool, m_shift, m_cnt;
  longint      m_acc [4];
  longint      m_max [4];

  layers_mc_if #(.DEPTH_NB(DEPTH_NB), .GROUP_NB(GROUP_NB), .IMG_WIDTH(IMG_WIDTH),
                 .KER_WIDTH(KER_WIDTH)) lif ();

  layers_mc #(.DEPTH_NB(DEPTH_NB), .GROUP_NB(GROUP_NB), .IMG_WIDTH(IMG_WIDTH),
              .KER_WIDTH(KER_WIDTH), .ACC_GUARD(8), .FIFO_DEPTH(4), .CFG_DWIDTH(32),
              .CFG_AWIDTH(5), .CFG_LAYERS(CFG_LAYERS)) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .bus(lif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [255:0] ker_chan(input int k0, input int k1, input int k2, input int k3);
    logic [255:0] w;
    int k [4];
    k = '{k0, k1, k2, k3};
    for (int d = 0; d < 4; d++)
      for (int g = 0; g < 4; g++)
        w[(d*4+g)*16 +: 16] = 16'(k[d]);
    return w;
  endfunction

  // result_rdy has a single driver, applied 2 time units after each rising edge
  initial begin
    lif.result_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      lif.result_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && lif.result_val && lif.result_rdy) begin
        if (exp_q.size() == 0)
          check_eq("extra_result", 64'(lif.result_val), 64'd0);
        else
          check_eq("result", lif.result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] iw, input logic [255:0] kw, input logic last);
    int waited = 0;
    lif.image      = iw;
    lif.kernel     = kw;
    lif.image_last = last;
    lif.image_val  = 1'b1;
    forever begin
      @(negedge clk);
      if (lif.image_rdy) break;
      waited++;
      if (waited >= 300) begin
        check_eq("accept_timeout", 64'(lif.image_rdy), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    lif.image_val = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    cfg_addr  = addr;
    cfg_data  = data;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || lif.result_val) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 2000)
      check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic longint wrap40(input longint v);
    return (v <<< 24) >>> 24;
  endfunction

  task automatic model_beat(input logic [63:0] iw, input logic [255:0] kw);
    for (int d = 0; d < 4; d++)
      for (int g = 0; g < 4; g++)
        m_acc[d] = wrap40(m_acc[d] + longint'($signed(kw[(d*4+g)*16 +: 16])) *
                                     longint'($signed(iw[g*16 +: 16])));
  endtask

  task automatic model_last();
    longint vals [4];
    longint v;
    logic   emit = 1'b0;
    logic [63:0] w;
    int pn = (m_pool == 0) ? 1 : m_pool;
    if (m_mode[0]) begin
      emit = 1'b1;
      vals = m_acc;
    end else begin
      for (int d = 0; d < 4; d++)
        if (m_cnt == 0 || m_acc[d] > m_max[d]) m_max[d] = m_acc[d];
      m_cnt++;
      if (m_cnt == pn) begin
        emit  = 1'b1;
        vals  = m_max;
        m_cnt = 0;
      end
    end
    if (emit) begin
      for (int d = 0; d < 4; d++) begin
        v = vals[d];
        if (!m_mode[1] && v < 0) v = 0;
        v = v >>> m_shift;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        w[d*16 +: 16] = 16'(v);
      end
      exp_q.push_back(w);
    end
    for (int d = 0; d < 4; d++) m_acc[d] = 0;
  endtask

  initial begin
    logic [63:0]  iw;
    logic [255:0] kw;
    logic [31:0]  cw;
    int w;

    lif.image = '0;
    lif.kernel = '0;
    lif.image_last = 1'b0;
    lif.image_val = 1'b0;

    #12;
    check_eq("rst_image_rdy", 64'(lif.image_rdy), 64'd1);
    check_eq("rst_kernel_rdy", 64'(lif.kernel_rdy), 64'd1);
    check_eq("rst_result_val", 64'(lif.result_val), 64'd0);
    check_eq("rst_result", lif.result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single vector 10.0 on every channel, with 6-edge latency
    cfg_write(5'(CFG_LAYERS), 32'h0001_0C00);
    exp_q.push_back(pack4(2560, 2560, 2560, 2560));
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    repeat (6) @(negedge clk);
    check_eq("lat_early", 64'(lif.result_val), 64'd0);
    @(negedge clk);
    check_eq("lat_on", 64'(lif.result_val), 64'd1);
    @(posedge clk);
    #1;
    drain();

    // two-beat accumulation, then ReLU on/off on a negative vector
    exp_q.push_back(pack4(5120, 5120, 5120, 5120));
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b0);
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    exp_q.push_back(pack4(0, 0, 0, 0));
    send_beat(pack4(-1280, -1536, -1792, -2048), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    drain();
    cfg_write(5'(CFG_LAYERS), 32'h0201_0C00);
    exp_q.push_back(pack4(-6656, -6656, -6656, -6656));
    send_beat(pack4(-1280, -1536, -1792, -2048), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    drain();

    // pooling over two vectors, then bypass
    cfg_write(5'(CFG_LAYERS), 32'h0002_0C00);
    exp_q.push_back(pack4(5120, 5120, 5120, 5120));
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    send_beat(pack4(512, 1024, 1536, 2048), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    drain();
    cfg_write(5'(CFG_LAYERS), 32'h0102_0C00);
    exp_q.push_back(pack4(2560, 2560, 2560, 2560));
    exp_q.push_back(pack4(5120, 5120, 5120, 5120));
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    send_beat(pack4(512, 1024, 1536, 2048), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    drain();

    // saturation both ways
    cfg_write(5'(CFG_LAYERS), 32'h0001_0C00);
    exp_q.push_back(pack4(32767, 32767, 32767, 32767));
    send_beat(pack4(32512, 32512, 32512, 32512), ker_chan(28672, 28672, 28672, 28672), 1'b1);
    drain();
    cfg_write(5'(CFG_LAYERS), 32'h0201_0C00);
    exp_q.push_back(pack4(-32768, -32768, -32768, -32768));
    send_beat(pack4(32512, 32512, 32512, 32512), ker_chan(-28672, -28672, -28672, -28672), 1'b1);
    drain();

    // backpressure: FIFO fills after four vectors
    cfg_write(5'(CFG_LAYERS), 32'h0001_0C00);
    fixed_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(pack4(2560*k, 2560*k, 2560*k, 2560*k));
      send_beat(pack4(256*k, 512*k, 768*k, 1024*k), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    end
    @(negedge clk);
    check_eq("bp_full", 64'(lif.image_rdy), 64'd0);
    repeat (10) @(negedge clk);
    check_eq("bp_fifo_val", 64'(lif.result_val), 64'd1);
    check_eq("bp_stall", 64'(lif.image_rdy), 64'd0);
    @(posedge clk);
    #1;
    fixed_rdy = 1'b1;
    @(negedge clk);
    check_eq("bp_pre_pop", 64'(lif.image_rdy), 64'd0);
    @(negedge clk);
    check_eq("bp_rdy_back", 64'(lif.image_rdy), 64'd1);
    @(posedge clk);
    #1;
    for (int k = 5; k <= 6; k++) begin
      exp_q.push_back(pack4(2560*k, 2560*k, 2560*k, 2560*k));
      send_beat(pack4(256*k, 512*k, 768*k, 1024*k), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    end
    drain();

    // per-channel kernels and a cfg write landing mid-vector
    kw = ker_chan(4096, 8192, -4096, 2048);
    exp_q.push_back(pack4(2560, 5120, 0, 1280));
    send_beat(pack4(256, 512, 768, 1024), kw, 1'b1);
    drain();
    exp_q.push_back(pack4(5120, 10240, 0, 2560));
    send_beat(pack4(256, 512, 768, 1024), kw, 1'b0);
    cfg_write(5'(CFG_LAYERS), 32'h0201_0C00);
    send_beat(pack4(256, 512, 768, 1024), kw, 1'b1);
    drain();
    exp_q.push_back(pack4(2560, 5120, -2560, 1280));
    send_beat(pack4(256, 512, 768, 1024), kw, 1'b1);
    drain();
    cfg_write(5'(CFG_LAYERS + 1), 32'h0001_0C00);
    exp_q.push_back(pack4(2560, 5120, -2560, 1280));
    send_beat(pack4(256, 512, 768, 1024), kw, 1'b1);
    drain();

    // asynchronous reset with a result queued and a partial vector in flight
    fixed_rdy = 1'b0;
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b1);
    w = 0;
    while (!lif.result_val && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_eq("pre_reset_val", 64'(lif.result_val), 64'd1);
    send_beat(pack4(256, 512, 768, 1024), ker_chan(4096, 4096, 4096, 4096), 1'b0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_result_val", 64'(lif.result_val), 64'd0);
    check_eq("arst_image_rdy", 64'(lif.image_rdy), 64'd1);
    check_eq("arst_result", lif.result, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fixed_rdy = 1'b1;
    exp_q.push_back(pack4(10, 10, 10, 10));
    send_beat(pack4(1, 2, 3, 4), ker_chan(1, 1, 1, 1), 1'b1);
    drain();

    // randomized rounds against the reference model
    m_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      m_acc[d] = 0;
      m_max[d] = 0;
    end
    rand_rdy = 1'b1;
    for (int r = 0; r < 14; r++) begin
      int pn, nvec, nb;
      cfg_write(5'(CFG_LAYERS) ^ 5'($urandom_range(1, 31)), $urandom());
      cw = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 20)),
            8'($urandom())};
      cfg_write(5'(CFG_LAYERS), cw);
      m_mode  = cw[25:24];
      m_pool  = int'(cw[23:16]);
      m_shift = int'(cw[15:8]);
      pn   = (m_pool == 0) ? 1 : m_pool;
      nvec = m_mode[0] ? $urandom_range(1, 4) : pn * $urandom_range(1, 3);
      for (int v = 0; v < nvec; v++) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          iw = {$urandom(), $urandom()};
          for (int q = 0; q < 8; q++) kw[q*32 +: 32] = $urandom();
          model_beat(iw, kw);
          if (b == nb - 1) model_last();
          send_beat(iw, kw, 1'(b == nb - 1));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
        end
      end
      drain();
    end
    rand_rdy = 1'b0;
    drain();
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/layers_mc.md
# layers_mc

Multi-channel successor to the convolution back-end layer stage. Each of DEPTH_NB output channels multiplies a shared GROUP_NB-wide image beat by its own kernel slice, sums the lanes and accumulates across beats until `image_last`. The finished value is max-pooled over a configurable window, passed through an optional ReLU, rescaled with saturation and written to a result FIFO. Flow control is credit-based, so `image_rdy` never admits a vector the FIFO cannot hold. Sits between the image/kernel buffers and the output writer; configured over the shared cfg bus.

## Interface
- DEPTH_NB, 4, number of output channels
- GROUP_NB, 4, image lanes per beat
- IMG_WIDTH, 16, signed image/result width
- KER_WIDTH, 16, signed kernel width
- ACC_GUARD, 8, accumulator guard bits; ACC_W = IMG_WIDTH+KER_WIDTH+ACC_GUARD
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)
- CFG_DWIDTH, 32, cfg data width
- CFG_AWIDTH, 5, cfg address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cfg_data  in  CFG_DWIDTH  {mode[31:24], pool_nb[23:16], shift[15:8], head[7:0]}
- cfg_addr  in  CFG_AWIDTH  captured only when equal to CFG_LAYERS
- cfg_valid  in  1  cfg write strobe
- kernel  in  GROUP_NB*KER_WIDTH*DEPTH_NB  channel d lane g at [(d*GROUP_NB+g)*KER_WIDTH +: KER_WIDTH]
- kernel_rdy  out  1  equals image_rdy; kernel is consumed with the image beat
- image  in  GROUP_NB*IMG_WIDTH  lane g at [g*IMG_WIDTH +: IMG_WIDTH]
- image_last  in  1  final beat of a vector
- image_val  in  1  beat valid
- image_rdy  out  1  beat accepted when image_val & image_rdy
- result  out  IMG_WIDTH*DEPTH_NB  channel d at [d*IMG_WIDTH +: IMG_WIDTH]
- result_val  out  1  FIFO non-empty
- result_rdy  in  1  pop when result_val & result_rdy

## Operation
- mode bit0 bypasses pooling, mode bit1 disables ReLU, mode[7:2] are ignored; head is ignored but kept for format compatibility; pool_nb=0 is treated as 1.
- Config is written to a pending register. It becomes active on the first cycle with no partial vector, pool count 0 and no vector in stages 1-5. A later write before that point overwrites the pending value. Reset config: mode=0, pool_nb=1, shift=0.
- Stage 1: register GROUP_NB×DEPTH_NB signed products.
- Stage 2: register the per-channel lane sum, sign-extended to ACC_W.
- Stage 3: accumulator. The first beat loads, later beats add. On last, the value is emitted and the accumulator clears. Overflow wraps at ACC_W.
- Stage 4: pool. Keeps a per-channel running signed max over pool_nb emitted vectors and emits on the pool_nb-th vector, then its counter resets. In bypass every vector is emitted.
- Stage 5: optional ReLU (negative becomes 0), then arithmetic shift right by shift. The result saturates to [-2^(IMG_WIDTH-1), 2^(IMG_WIDTH-1)-1], after which it is written to the FIFO.
- Credits: counter reset to FIFO_DEPTH; image_rdy = (credits != 0).
  - Accepting a last beat takes one credit.
  - A vector absorbed by the pool without output returns its credit at stage 4.
  - A FIFO pop returns one credit.
  - A take and a return in the same cycle leave the count unchanged.
- Non-last beats also require credits != 0; no beat is accepted while image_rdy=0.

## Timing
- Reset values: image_rdy=1, kernel_rdy=1, result_val=0, result=0, credits=FIFO_DEPTH; accumulators, pool and FIFO pointers are cleared.
- Last beat accepted at edge T gives result_val=1 after edge T+6 when the FIFO was empty (pool_nb=1 or bypass).
- Throughput is one beat per cycle while credits remain. A FIFO push and pop in the same cycle leave the occupancy unchanged.
- When the FIFO is full, credits=0 and image_rdy=0. The cycle after a pop, image_rdy=1.
- Reset asserted mid-vector discards all partial state immediately (asynchronous); outputs return to their reset values.

## Test plan
- Single vector, shift=12, pool_nb=1, kernel all 1.0 (4096), image {1,2,3,4}·256, last: result=10.0 (0x0A00) on every channel, result_val 6 cycles after acceptance.
- Two-beat vector, same data twice: 20.0 (0x1400). Then image {-5,-6,-7,-8}·256 with ReLU on gives 0x0000, with mode=2 gives -26.0 (0xE600).
- pool_nb=2, vectors 10.0 then 20.0: single result 20.0; bypass (mode=1): two results 10.0, 20.0.
- Saturation: lanes 127.0, kernel 7.0, shift=12: result 0x7FFF; negated kernel gives 0x8000.
- Backpressure: result_rdy=0, send 6 single-beat vectors. image_rdy falls after the 4th last-beat acceptance. With result_rdy=1, all 6 results emerge in order with none lost, and image_rdy rises the cycle after the first pop.
- Per-channel kernels 1.0/2.0/-1.0/0.5 with image {1,2,3,4}: results 10, 20, -10 (0 with ReLU), 5. A cfg write mid-vector takes effect only on the following vector.
